// File: rtl/heartbeat_pwm_gen.sv
// Board-to-board heartbeat transmitter: whole-period 50% PWM, gated by enable
// and a kick watchdog that stops emission cleanly when the local core hangs.
`ifndef OSC
`define OSC 50000
`endif

module heartbeat_pwm_gen #(
    parameter int unsigned PERIOD          = `OSC,
    parameter int unsigned HIGH_TIME       = PERIOD / 2,
    parameter int unsigned TIMEOUT_PERIODS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic kick,
    output logic pwm,
    output logic running,
    output logic period_tick,
    output logic timeout
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_PERIODS);
    localparam logic [31:0] LAST   = 32'(PERIOD - 1);
    localparam logic [31:0] HIGH   = 32'(HIGH_TIME);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       phase_q, phase_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              pwm_q, running_q, period_tick_q, timeout_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wd_d    = kick ? '0 : wd_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                // A kick in the same cycle clears the watchdog, so start is allowed at once.
                if (en && (wd_d != WD_MAX)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (phase_q == LAST) begin
                    if (!kick) begin
                        wd_d = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_W'(1);
                    end
                    phase_d = '0;
                    if (!en || (wd_d == WD_MAX)) begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with phase_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            wd_q          <= '0;
            pwm_q         <= 1'b0;
            running_q     <= 1'b0;
            period_tick_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            wd_q          <= wd_d;
            pwm_q         <= (state_d == RUN) && (phase_d < HIGH);
            running_q     <= (state_d == RUN);
            period_tick_q <= (state_d == RUN) && (phase_d == LAST);
            timeout_q     <= (wd_d == WD_MAX);
        end
    end

    assign pwm         = pwm_q;
    assign running     = running_q;
    assign period_tick = period_tick_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_heartbeat_pwm_gen.sv
// Directed bench for heartbeat_pwm_gen with PERIOD=100, HIGH_TIME=50, TIMEOUT_PERIODS=4.
module tb_heartbeat_pwm_gen;

    logic clk = 1'b0;
    logic rst, en, kick;
    logic pwm, running, period_tick, timeout;

    int total = 0;
    int bad   = 0;

    heartbeat_pwm_gen #(
        .PERIOD(100),
        .HIGH_TIME(50),
        .TIMEOUT_PERIODS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .kick(kick),
        .pwm(pwm),
        .running(running),
        .period_tick(period_tick),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int e_pwm, e_run, e_tick, e_to;
    int n_pwm, n_tick;
    logic xp, xr, xt, xo;

    initial begin
        rst = 1'b1; en = 1'b0; kick = 1'b0;
        repeat (3) step();
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_timeout", int'(timeout), 0);

        // Released with en low: nothing is emitted
        rst = 1'b0;
        n_pwm = 0; e_run = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (pwm !== 1'b0) n_pwm++;
            if (running !== 1'b0) e_run++;
        end
        chk("idle_pwm_cycles", n_pwm, 0);
        chk("idle_running_cycles", e_run, 0);

        // Steady heartbeat, kick every 150 cycles
        en = 1'b1;
        e_pwm = 0; e_run = 0; e_tick = 0; e_to = 0; n_pwm = 0; n_tick = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            kick = 1'b0;
            xp = ((i % 100) < 50);
            xt = ((i % 100) == 99);
            if (pwm !== xp) e_pwm++;
            if (period_tick !== xt) e_tick++;
            if (running !== 1'b1) e_run++;
            if (timeout !== 1'b0) e_to++;
            if (pwm === 1'b1) n_pwm++;
            if (period_tick === 1'b1) n_tick++;
            if ((i % 150) == 149) kick = 1'b1;
        end
        kick = 1'b0;
        chk("steady_pwm_errs", e_pwm, 0);
        chk("steady_tick_errs", e_tick, 0);
        chk("steady_running_errs", e_run, 0);
        chk("steady_timeout_errs", e_to, 0);
        chk("steady_pwm_high_count", n_pwm, 500);
        chk("steady_tick_count", n_tick, 10);

        // Clean stop: drop en at phase 20, period must finish in full
        repeat (21) step();
        en = 1'b0;
        e_pwm = 0; e_run = 0; e_tick = 0;
        for (int j = 0; j < 200; j++) begin
            step();
            xp = (j < 29);
            xr = (j < 79);
            xt = (j == 78);
            if (pwm !== xp) e_pwm++;
            if (running !== xr) e_run++;
            if (period_tick !== xt) e_tick++;
        end
        chk("stop_pwm_errs", e_pwm, 0);
        chk("stop_running_errs", e_run, 0);
        chk("stop_tick_errs", e_tick, 0);

        // Clear watchdog while idle, then run with no kicks until expiry
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("idle_kick_no_start", int'(running), 0);
        en = 1'b1;
        e_pwm = 0; e_run = 0; e_tick = 0; e_to = 0;
        for (int k = 0; k < 405; k++) begin
            step();
            xp = (k < 400) && ((k % 100) < 50);
            xr = (k < 400);
            xt = (k < 400) && ((k % 100) == 99);
            xo = (k >= 400);
            if (pwm !== xp) e_pwm++;
            if (running !== xr) e_run++;
            if (period_tick !== xt) e_tick++;
            if (timeout !== xo) e_to++;
        end
        chk("wd_pwm_errs", e_pwm, 0);
        chk("wd_running_errs", e_run, 0);
        chk("wd_tick_errs", e_tick, 0);
        chk("wd_timeout_errs", e_to, 0);

        // Kick restarts on the very next cycle and clears timeout
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("restart_running", int'(running), 1);
        chk("restart_pwm", int'(pwm), 1);
        chk("restart_timeout", int'(timeout), 0);

        // Kick only on period-end cycles: emission never stops
        e_pwm = 0; e_run = 0; e_to = 0; n_tick = 0;
        for (int n = 1; n <= 2000; n++) begin
            step();
            kick = period_tick;
            xp = ((n % 100) < 50);
            if (pwm !== xp) e_pwm++;
            if (running !== 1'b1) e_run++;
            if (timeout !== 1'b0) e_to++;
            if (period_tick === 1'b1) n_tick++;
        end
        kick = 1'b0;
        chk("endkick_pwm_errs", e_pwm, 0);
        chk("endkick_running_errs", e_run, 0);
        chk("endkick_timeout_errs", e_to, 0);
        chk("endkick_tick_count", n_tick, 20);

        // Reset mid-pulse truncates immediately
        chk("pre_reset_pwm", int'(pwm), 1);
        rst = 1'b1;
        step();
        chk("midrst_pwm", int'(pwm), 0);
        chk("midrst_running", int'(running), 0);
        rst = 1'b0; en = 1'b0;
        step();
        chk("post_rst_idle", int'(running), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
